// File: rtl/sid_write_sequencer.sv
// Buffers host register-write commands and replays them onto the SID write port
// with programmable setup/hold around a single-cycle wr_en strobe.
module sid_write_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_voice,
    input  logic [2:0]                    cmd_addr,
    input  logic [7:0]                    cmd_data,
    input  logic                          flush,
    output logic [2:0]                    reg_addr,
    output logic                          voice_sel,
    output logic [7:0]                    wr_data,
    output logic                          wr_en,
    output logic                          busy,
    output logic                          drop,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 12;
    localparam int unsigned TMR_W = 4;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ENT_W-1:0] head;
    logic             head_ok;
    logic             push;
    logic             pop;

    // Entry layout: {voice[11], addr[10:8], data[7:0]}; addresses 3 and 7 are unmapped.
    assign cmd_ready = rst_n & ~flush & (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state == IDLE) & (fifo_count != '0) & ~flush;
    assign head      = mem[rd_ptr];
    assign head_ok   = (head[9:8] != 2'b11);
    assign busy      = (state != IDLE) | (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_voice, cmd_addr, cmd_data};
        end
    end

    // FIFO pointers and occupancy; flush discards everything queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Write sequencer: IDLE pop -> SETUP -> STROBE -> HOLD -> IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            reg_addr  <= '0;
            voice_sel <= 1'b0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_ok) begin
                            voice_sel <= head[11];
                            reg_addr  <= head[10:8];
                            wr_data   <= head[7:0];
                            tmr       <= '0;
                            state     <= SETUP;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (tmr == TMR_W'(SETUP_CYC - 1)) begin
                        tmr   <= '0;
                        wr_en <= 1'b1;
                        state <= STROBE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                STROBE: begin
                    wr_en <= 1'b0;
                    tmr   <= '0;
                    state <= HOLD;
                end
                HOLD: begin
                    if (tmr == TMR_W'(HOLD_CYC - 1)) begin
                        tmr   <= '0;
                        state <= IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sid_write_sequencer.sv
// Bench for sid_write_sequencer: scoreboard of expected writes checked on every
// strobe, plus timed sequences for latency, flush, reset and a slow-timing instance.
module tb_sid_write_sequencer;

    typedef struct packed {
        logic       v;
        logic [2:0] a;
        logic [7:0] d;
    } ent_t;

    typedef struct {
        logic       v;
        logic [2:0] a;
        logic [7:0] d;
        logic       exp_drop;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_voice = 1'b0, flush = 1'b0;
    logic [2:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, voice_sel, wr_en, busy, drop;
    logic [2:0] reg_addr;
    logic [7:0] wr_data;
    logic [2:0] fifo_count;

    logic       b_valid = 1'b0, b_voice = 1'b0, b_flush = 1'b0;
    logic [2:0] b_addr = '0;
    logic [7:0] b_data = '0;
    logic       b_ready, b_voice_sel, b_wr_en, b_busy, b_drop;
    logic [2:0] b_reg_addr;
    logic [7:0] b_wr_data;
    logic [2:0] b_count;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    int   exp_drops = 0;
    int   drop_seen = 0;
    int   cyc = 0;
    int   last_cyc = -1;
    int   period = 0;
    logic prev_wr_en = 1'b0;
    logic saw_full = 1'b0;
    vec_t vecs[9];

    always #5 clk = ~clk;

    sid_write_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_voice(cmd_voice), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .flush(flush),
        .reg_addr(reg_addr), .voice_sel(voice_sel), .wr_data(wr_data), .wr_en(wr_en),
        .busy(busy), .drop(drop), .fifo_count(fifo_count)
    );

    sid_write_sequencer #(.FIFO_DEPTH(4), .SETUP_CYC(3), .HOLD_CYC(2)) dut_slow (
        .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_voice(b_voice), .cmd_addr(b_addr), .cmd_data(b_data), .flush(b_flush),
        .reg_addr(b_reg_addr), .voice_sel(b_voice_sel), .wr_data(b_wr_data), .wr_en(b_wr_en),
        .busy(b_busy), .drop(b_drop), .fifo_count(b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe monitor: each wr_en cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (drop === 1'b1) drop_seen++;
            if (wr_en === 1'b1) begin
                chk("strobe_gap", 32'(prev_wr_en), 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe actual addr=%0d data=%0h required none", reg_addr, wr_data);
                end else begin
                    ent_t e;
                    e = q.pop_front();
                    chk("strobe_addr", 32'(reg_addr), 32'(e.a));
                    chk("strobe_voice", 32'(voice_sel), 32'(e.v));
                    chk("strobe_data", 32'(wr_data), 32'(e.d));
                end
                if (period != 0 && last_cyc >= 0) chk("strobe_period", 32'(cyc - last_cyc), 32'(period));
                last_cyc = cyc;
            end
        end
        prev_wr_en = wr_en;
        cyc++;
    end

    task automatic send(input logic v, input logic [2:0] a, input logic [7:0] d, input logic exp_drop);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_voice = v;
        cmd_addr  = a;
        cmd_data  = d;
        while (n < 50) begin
            if (fifo_count == 3'd4) begin
                chk("ready_low_when_full", 32'(cmd_ready), 0);
                saw_full = 1'b1;
            end
            if (cmd_ready) break;
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual ready=0 required ready=1");
        end else begin
            if (exp_drop) exp_drops++;
            else q.push_back('{v, a, d});
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || wr_en) && n < 200) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual busy=1 required busy=0");
        end
        tick();
    endtask

    task automatic end_phase(input string name);
        wait_idle();
        chk({name, "_sb_empty"}, 32'(q.size()), 0);
        chk({name, "_drops"}, 32'(drop_seen), 32'(exp_drops));
    endtask

    initial begin
        int t1, t2;
        vecs[0] = '{1'b0, 3'd0, 8'h11, 1'b0};
        vecs[1] = '{1'b1, 3'd1, 8'h22, 1'b0};
        vecs[2] = '{1'b0, 3'd2, 8'h33, 1'b0};
        vecs[3] = '{1'b1, 3'd4, 8'h44, 1'b0};
        vecs[4] = '{1'b0, 3'd5, 8'h55, 1'b0};
        vecs[5] = '{1'b1, 3'd6, 8'h66, 1'b0};
        vecs[6] = '{1'b0, 3'd3, 8'hAA, 1'b1};
        vecs[7] = '{1'b1, 3'd7, 8'hBB, 1'b1};
        vecs[8] = '{1'b0, 3'd2, 8'h10, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_reg_addr", 32'(reg_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // Single write latency
        send(1'b0, 3'd1, 8'h5A, 1'b0);
        chk("single_e0_count", 32'(fifo_count), 1);
        chk("single_e0_addr", 32'(reg_addr), 0);
        tick();
        chk("single_e1_addr", 32'(reg_addr), 1);
        chk("single_e1_data", 32'(wr_data), 32'h5A);
        chk("single_e1_wr_en", 32'(wr_en), 0);
        chk("single_e1_busy", 32'(busy), 1);
        tick();
        chk("single_e2_wr_en", 32'(wr_en), 1);
        tick();
        chk("single_e3_wr_en", 32'(wr_en), 0);
        chk("single_e3_busy", 32'(busy), 1);
        tick();
        chk("single_e4_busy", 32'(busy), 0);
        chk("single_e4_addr_kept", 32'(reg_addr), 1);
        end_phase("single");

        // Back-to-back burst from the table
        period = 4;
        last_cyc = -1;
        for (int i = 0; i < 6; i++) send(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].exp_drop);
        chk("burst_full_seen", 32'(saw_full), 1);
        end_phase("burst");
        period = 0;

        // Unmapped addresses are dropped
        for (int i = 6; i < 9; i++) send(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].exp_drop);
        end_phase("invalid");

        // Flush during the strobe of a queued write
        send(1'b1, 3'd4, 8'h77, 1'b0);
        send(1'b0, 3'd1, 8'hC1, 1'b0);
        send(1'b1, 3'd2, 8'hC2, 1'b0);
        send(1'b0, 3'd5, 8'hC3, 1'b0);
        send(1'b1, 3'd6, 8'hC4, 1'b0);
        tick();
        tick();
        chk("flush_in_strobe", 32'(wr_en), 1);
        chk("flush_strobe_data", 32'(wr_data), 32'hC1);
        while (q.size() > 1) q.delete(q.size() - 1);
        flush = 1'b1;
        #1;
        chk("flush_ready_low", 32'(cmd_ready), 0);
        tick();
        chk("flush_count", 32'(fifo_count), 0);
        chk("flush_strobe_end", 32'(wr_en), 0);
        flush = 1'b0;
        end_phase("flush");

        // Reset during SETUP
        send(1'b0, 3'd6, 8'h99, 1'b0);
        tick();
        chk("rmw_loaded", 32'(reg_addr), 6);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("rmw_ready_low", 32'(cmd_ready), 0);
        tick();
        chk("rmw_wr_en", 32'(wr_en), 0);
        chk("rmw_addr", 32'(reg_addr), 0);
        chk("rmw_data", 32'(wr_data), 0);
        chk("rmw_voice", 32'(voice_sel), 0);
        chk("rmw_count", 32'(fifo_count), 0);
        chk("rmw_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();
        send(1'b1, 3'd5, 8'h3C, 1'b0);
        end_phase("rmw");

        // Slow timing instance: SETUP_CYC=3, HOLD_CYC=2
        b_valid = 1'b1;
        b_voice = 1'b0;
        b_addr  = 3'd4;
        b_data  = 8'hE1;
        tick();
        b_voice = 1'b1;
        b_addr  = 3'd0;
        b_data  = 8'hE2;
        tick();
        b_valid = 1'b0;
        chk("slow_loaded", 32'(b_reg_addr), 4);
        t1 = -1;
        t2 = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (b_wr_en) begin
                if (t1 < 0) begin
                    t1 = k;
                    chk("slow_data1", 32'(b_wr_data), 32'hE1);
                end else if (t2 < 0) begin
                    t2 = k;
                    chk("slow_data2", 32'(b_wr_data), 32'hE2);
                end
            end
        end
        chk("slow_setup_lat", 32'(t1), 3);
        chk("slow_period", 32'(t2 - t1), 7);
        chk("slow_idle", 32'(b_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
